// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared state encodings and control-vector constants
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 16;

  typedef struct packed {
    logic pc_en;
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic en_memwb;
    logic bubble_idex;
    logic flush_ifid;
  } ctl_t;

  localparam ctl_t CTL_FREEZE = 7'b00000_00;
  localparam ctl_t CTL_RUN    = 7'b11111_00;
  // Front end held, back end drains with a NOP entering IDEX.
  localparam ctl_t CTL_HOLD   = 7'b00111_10;
  localparam ctl_t CTL_BRANCH = 7'b11111_11;

endpackage

// File: rtl/pipe_stall_ctrl_stall_timer.sv
// rtl/pipe_stall_ctrl_stall_timer.sv - clear/inc wait counter with terminal count at TIMEOUT-1
module stall_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush sequencer driving pipeline register enables
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_mem_stall,
  input  logic             inst_mem_done,
  input  logic             data_mem_stall,
  input  logic             data_mem_done,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             halt_wb,
  input  logic             err_wb,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t state, state_nxt;
  ctl_t   ctl;
  logic   pend_flush, pend_nxt;
  logic   use_run, ignore_data, to_fire;
  logic   wait_tc, timer_clr, timer_inc, stall_any;
  logic   in_wait, nxt_wait;

  always_comb begin
    ctl         = CTL_FREEZE;
    state_nxt   = state;
    pend_nxt    = pend_flush;
    use_run     = 1'b0;
    ignore_data = 1'b0;
    to_fire     = 1'b0;
    case (state)
      RUN: use_run = 1'b1;
      DWAIT: begin
        if (halt_wb || err_wb) begin
          state_nxt = HALT;
        end else if (data_mem_done) begin
          use_run     = 1'b1;
          ignore_data = 1'b1;
        end else if (wait_tc) begin
          to_fire   = 1'b1;
          state_nxt = HALT;
        end
      end
      IWAIT: begin
        if (halt_wb || err_wb) begin
          state_nxt = HALT;
        end else if (data_mem_stall && !data_mem_done) begin
          state_nxt = DWAIT;
        end else if (inst_mem_done) begin
          use_run = 1'b1;
        end else if (wait_tc) begin
          to_fire   = 1'b1;
          state_nxt = HALT;
        end else begin
          ctl = CTL_HOLD;
          // The branch leaves EX while fetch is stuck; remember it for the done cycle.
          if (branch_taken) pend_nxt = 1'b1;
        end
      end
      default: ;
    endcase

    if (use_run) begin
      state_nxt = RUN;
      if (halt_wb || err_wb) begin
        state_nxt = HALT;
      end else if (!ignore_data && data_mem_stall && !data_mem_done) begin
        state_nxt = DWAIT;
      end else if (inst_mem_stall && !inst_mem_done) begin
        ctl       = CTL_HOLD;
        state_nxt = IWAIT;
      end else if (load_use) begin
        ctl = CTL_HOLD;
      end else if (branch_taken || pend_flush) begin
        ctl      = CTL_BRANCH;
        pend_nxt = 1'b0;
      end else begin
        ctl = CTL_RUN;
      end
    end
  end

  assign pc_en       = rst & ctl.pc_en;
  assign en_ifid     = rst & ctl.en_ifid;
  assign en_idex     = rst & ctl.en_idex;
  assign en_exmem    = rst & ctl.en_exmem;
  assign en_memwb    = rst & ctl.en_memwb;
  assign bubble_idex = rst & ctl.bubble_idex;
  assign flush_ifid  = rst & ctl.flush_ifid;

  assign stall_any = ~(ctl.pc_en & ctl.en_ifid & ctl.en_idex & ctl.en_exmem & ctl.en_memwb);

  assign in_wait   = (state == DWAIT) || (state == IWAIT);
  assign nxt_wait  = (state_nxt == DWAIT) || (state_nxt == IWAIT);
  assign timer_clr = nxt_wait && (state_nxt != state);
  assign timer_inc = in_wait && (state_nxt == state);

  stall_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk(clk),
    .rst(rst),
    .clr(timer_clr),
    .inc(timer_inc),
    .tc (wait_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      pend_flush   <= 1'b0;
      halted       <= 1'b0;
      timeout_err  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state      <= state_nxt;
      pend_flush <= pend_nxt;
      if (state_nxt == HALT) halted <= 1'b1;
      if (to_fire) timeout_err <= 1'b1;
      if ((state != HALT) && stall_any && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  localparam int CW = 4;
  localparam int TO = 8;

  localparam logic [6:0] FRZ  = 7'b00000_00;
  localparam logic [6:0] RUN1 = 7'b11111_00;
  localparam logic [6:0] HOLD = 7'b00111_10;
  localparam logic [6:0] BRF  = 7'b11111_11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inst_mem_stall = 1'b0, inst_mem_done = 1'b0;
  logic data_mem_stall = 1'b0, data_mem_done = 1'b0;
  logic load_use = 1'b0, branch_taken = 1'b0, halt_wb = 1'b0, err_wb = 1'b0;
  logic pc_en, en_ifid, en_idex, en_exmem, en_memwb, bubble_idex, flush_ifid;
  logic halted, timeout_err;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         nm;
    logic [6:0]    ctl;
    logic [CW-1:0] sc;
    logic          h;
    logic          t;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .TIMEOUT(TO),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_mem_stall(inst_mem_stall),
    .inst_mem_done (inst_mem_done),
    .data_mem_stall(data_mem_stall),
    .data_mem_done (data_mem_done),
    .load_use      (load_use),
    .branch_taken  (branch_taken),
    .halt_wb       (halt_wb),
    .err_wb        (err_wb),
    .pc_en         (pc_en),
    .en_ifid       (en_ifid),
    .en_idex       (en_idex),
    .en_exmem      (en_exmem),
    .en_memwb      (en_memwb),
    .bubble_idex   (bubble_idex),
    .flush_ifid    (flush_ifid),
    .halted        (halted),
    .timeout_err   (timeout_err),
    .stall_cycles  (stall_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, "/ctl"}, {25'd0, pc_en, en_ifid, en_idex, en_exmem, en_memwb, bubble_idex, flush_ifid},
          {25'd0, e.ctl});
      chk({e.nm, "/stall_cycles"}, {{(32-CW){1'b0}}, stall_cycles}, {{(32-CW){1'b0}}, e.sc});
      chk({e.nm, "/halted"}, {31'd0, halted}, {31'd0, e.h});
      chk({e.nm, "/timeout_err"}, {31'd0, timeout_err}, {31'd0, e.t});
    end
  end

  // v = {inst_stall, inst_done, data_stall, data_done, load_use, branch, halt, err}
  task automatic step(input logic r, input logic [7:0] v, input logic [6:0] c, input int s,
                      input logic h, input logic t, input string nm);
    exp_t e;
    rst = r;
    {inst_mem_stall, inst_mem_done, data_mem_stall, data_mem_done,
     load_use, branch_taken, halt_wb, err_wb} = v;
    e.nm  = nm;
    e.ctl = c;
    e.sc  = CW'(s);
    e.h   = h;
    e.t   = t;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(0, 8'h00, FRZ, 0, 0, 0, "reset0");
    step(0, 8'h00, FRZ, 0, 0, 0, "reset1");

    for (int i = 0; i < 10; i++) step(1, 8'h00, RUN1, 0, 0, 0, "idle");

    step(1, 8'h20, FRZ, 0, 0, 0, "dstall_run");
    step(1, 8'h20, FRZ, 1, 0, 0, "dwait1");
    step(1, 8'h20, FRZ, 2, 0, 0, "dwait2");
    step(1, 8'h30, RUN1, 3, 0, 0, "ddone");
    step(1, 8'h00, RUN1, 3, 0, 0, "after_ddone");
    step(1, 8'h30, RUN1, 3, 0, 0, "dsingle");
    step(1, 8'h00, RUN1, 3, 0, 0, "after_dsingle");

    step(1, 8'h08, HOLD, 3, 0, 0, "load_use");
    step(1, 8'h00, RUN1, 4, 0, 0, "after_lu");

    step(1, 8'h80, HOLD, 4, 0, 0, "istall_run");
    step(1, 8'h84, HOLD, 5, 0, 0, "iwait_branch");
    step(1, 8'h80, HOLD, 6, 0, 0, "iwait2");
    step(1, 8'h80, HOLD, 7, 0, 0, "iwait3");
    step(1, 8'h80, HOLD, 8, 0, 0, "iwait4");
    step(1, 8'h40, BRF, 9, 0, 0, "idone_flush");
    step(1, 8'h00, RUN1, 9, 0, 0, "after_idone");
    step(1, 8'h04, BRF, 9, 0, 0, "branch_run");
    step(1, 8'h00, RUN1, 9, 0, 0, "after_branch");

    step(0, 8'h00, FRZ, 0, 0, 0, "reset_t5");
    step(1, 8'h20, FRZ, 0, 0, 0, "to_enter");
    for (int i = 1; i <= 8; i++) step(1, 8'h20, FRZ, i, 0, 0, "to_wait");
    step(1, 8'h30, FRZ, 9, 1, 1, "to_late_done");
    step(1, 8'h00, FRZ, 9, 1, 1, "to_halted");

    step(0, 8'h00, FRZ, 0, 0, 0, "reset_t6");
    step(1, 8'h20, FRZ, 0, 0, 0, "h_dstall");
    step(1, 8'h22, FRZ, 1, 0, 0, "h_halt_in_dwait");
    step(1, 8'h00, FRZ, 2, 1, 0, "h_hold1");
    step(1, 8'h30, FRZ, 2, 1, 0, "h_hold2");
    step(0, 8'h00, FRZ, 0, 0, 0, "h_async_reset");
    step(1, 8'h00, RUN1, 0, 0, 0, "h_after_reset");
    step(1, 8'h01, FRZ, 0, 0, 0, "err_wb");
    step(1, 8'h00, FRZ, 1, 1, 0, "err_halted");

    step(0, 8'h00, FRZ, 0, 0, 0, "reset_t7");
    for (int k = 0; k < 17; k++) step(1, 8'h08, HOLD, (k < 15) ? k : 15, 0, 0, "sat");
    step(1, 8'h00, RUN1, 15, 0, 0, "sat_hold");

    @(negedge clk);
    #1;
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
